waveram_arbiter: RTL and testbench

Time-multiplexes the single-port wave RAM between `NUM_VOICES` NCO voices and the host wavetable-load path. Each cycle it grants the RAM to exactly one requester: a voice read, in round-robin slot order, or a host write. It returns each voice's fetched sample on a per-voice register with a valid pulse. It sits between the NCO bank (the `o_waveram_address` outputs) and the wave RAM macro, and feeds the mixer.

---
 rtl/waveram_arbiter.sv | 100 ++++++++++
 tb/tb_waveram_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/waveram_arbiter.sv
// Wave RAM arbiter: round-robin voice reads interleaved with host writes on a
// single-port RAM, returning each voice's fetched sample with a valid pulse.
module waveram_arbiter #(
    parameter int NUM_VOICES  = 4,
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 8,
    parameter int RAM_LATENCY = 1
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic [NUM_VOICES*ADDR_WIDTH-1:0] i_voice_address,
    input  logic                             i_host_write_request,
    input  logic [ADDR_WIDTH-1:0]            i_host_address,
    input  logic [DATA_WIDTH-1:0]            i_host_data,
    output logic                             o_host_write_ack,
    output logic [ADDR_WIDTH-1:0]            o_ram_address,
    output logic                             o_ram_write_enable,
    output logic [DATA_WIDTH-1:0]            o_ram_write_data,
    input  logic [DATA_WIDTH-1:0]            i_ram_read_data,
    output logic [NUM_VOICES*DATA_WIDTH-1:0] o_sample,
    output logic [NUM_VOICES-1:0]            o_sample_valid,
    output logic                             o_frame_start
);

    localparam int SLOT_W = $clog2(NUM_VOICES);

    logic [SLOT_W-1:0]                   r_slot;
    logic                                r_host_last;
    logic [RAM_LATENCY:0]                r_tag_valid;
    logic [RAM_LATENCY:0][SLOT_W-1:0]    r_tag_voice;
    logic [ADDR_WIDTH-1:0]               r_ram_address;
    logic                                r_ram_write_enable;
    logic [DATA_WIDTH-1:0]               r_ram_write_data;
    logic [NUM_VOICES*DATA_WIDTH-1:0]    r_sample;
    logic [NUM_VOICES-1:0]               r_sample_valid;
    logic                                r_frame_start;

    logic                                w_host_grant;
    logic [ADDR_WIDTH-1:0]               w_voice_address;
    logic [SLOT_W-1:0]                   w_ret_voice;

    // The host never wins two cycles in a row, so voices cannot be starved.
    assign w_host_grant    = i_host_write_request && !r_host_last;
    assign w_voice_address = i_voice_address[int'(r_slot)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_ret_voice     = r_tag_voice[RAM_LATENCY];

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_slot             <= '0;
            r_host_last        <= 1'b0;
            r_tag_valid        <= '0;
            r_tag_voice        <= '0;
            r_ram_address      <= '0;
            r_ram_write_enable <= 1'b0;
            r_ram_write_data   <= '0;
            r_sample           <= '0;
            r_sample_valid     <= '0;
            r_frame_start      <= 1'b0;
        end else begin
            for (int unsigned i = 1; i <= RAM_LATENCY; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_voice[i] <= r_tag_voice[i-1];
            end

            if (w_host_grant) begin
                r_ram_address      <= i_host_address;
                r_ram_write_enable <= 1'b1;
                r_ram_write_data   <= i_host_data;
                r_host_last        <= 1'b1;
                r_tag_valid[0]     <= 1'b0;
                r_tag_voice[0]     <= '0;
                r_frame_start      <= 1'b0;
            end else begin
                r_ram_address      <= w_voice_address;
                r_ram_write_enable <= 1'b0;
                r_host_last        <= 1'b0;
                r_tag_valid[0]     <= 1'b1;
                r_tag_voice[0]     <= r_slot;
                r_slot             <= r_slot + SLOT_W'(1);
                r_frame_start      <= (r_slot == '0);
            end

            // Tag leaving the pipeline lines up with the RAM data for its read.
            r_sample_valid <= '0;
            if (r_tag_valid[RAM_LATENCY]) begin
                r_sample[int'(w_ret_voice)*DATA_WIDTH +: DATA_WIDTH] <= i_ram_read_data;
                r_sample_valid[w_ret_voice] <= 1'b1;
            end
        end
    end

    assign o_host_write_ack   = w_host_grant;
    assign o_ram_address      = r_ram_address;
    assign o_ram_write_enable = r_ram_write_enable;
    assign o_ram_write_data   = r_ram_write_data;
    assign o_sample           = r_sample;
    assign o_sample_valid     = r_sample_valid;
    assign o_frame_start      = r_frame_start;

endmodule

// File: tb/tb_waveram_arbiter.sv
// Scoreboard bench for waveram_arbiter: stimulus queues expected sample returns
// and RAM writes; a negedge monitor pops and compares them as the DUT emits them.
module tb_waveram_arbiter;

    localparam int NV = 4;
    localparam int AW = 13;
    localparam int DW = 8;

    typedef struct {
        int         voice;
        logic [7:0] data;
    } sample_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } write_t;

    logic               i_clock;
    logic               i_reset;
    logic [NV*AW-1:0]   i_voice_address;
    logic               i_host_write_request;
    logic [AW-1:0]      i_host_address;
    logic [DW-1:0]      i_host_data;
    logic               o_host_write_ack;
    logic [AW-1:0]      o_ram_address;
    logic               o_ram_write_enable;
    logic [DW-1:0]      o_ram_write_data;
    logic [DW-1:0]      i_ram_read_data;
    logic [NV*DW-1:0]   o_sample;
    logic [NV-1:0]      o_sample_valid;
    logic               o_frame_start;

    int checks = 0;
    int errors = 0;
    sample_t exp_samples[$];
    write_t  exp_writes[$];

    waveram_arbiter #(
        .NUM_VOICES (NV),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RAM_LATENCY(1)
    ) dut (
        .i_clock             (i_clock),
        .i_reset             (i_reset),
        .i_voice_address     (i_voice_address),
        .i_host_write_request(i_host_write_request),
        .i_host_address      (i_host_address),
        .i_host_data         (i_host_data),
        .o_host_write_ack    (o_host_write_ack),
        .o_ram_address       (o_ram_address),
        .o_ram_write_enable  (o_ram_write_enable),
        .o_ram_write_data    (o_ram_write_data),
        .i_ram_read_data     (i_ram_read_data),
        .o_sample            (o_sample),
        .o_sample_valid      (o_sample_valid),
        .o_frame_start       (o_frame_start)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // One-cycle-latency RAM that returns the low address byte as data.
    always @(posedge i_clock) i_ram_read_data <= o_ram_address[7:0];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_voices(input int n);
        for (int i = 0; i < n; i++) begin
            sample_t s;
            s.voice = i % NV;
            s.data  = 8'((s.voice + 1) * 16);
            exp_samples.push_back(s);
        end
    endtask

    task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_t w;
        w.addr = a;
        w.data = d;
        exp_writes.push_back(w);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ram_address"}, 64'(o_ram_address), 64'h0);
        chk({tag, "_ram_we"}, 64'(o_ram_write_enable), 64'h0);
        chk({tag, "_ram_wdata"}, 64'(o_ram_write_data), 64'h0);
        chk({tag, "_sample"}, 64'(o_sample), 64'h0);
        chk({tag, "_sample_valid"}, 64'(o_sample_valid), 64'h0);
        chk({tag, "_frame_start"}, 64'(o_frame_start), 64'h0);
    endtask

    // Caller is at a falling edge; reset takes effect without a clock.
    task automatic assert_rst();
        #1 i_reset = 1'b0;
        #1 check_outputs_zero("reset");
    endtask

    task automatic release_rst();
        @(negedge i_clock);
        #1 i_reset = 1'b1;
    endtask

    // Monitor: every valid pulse and every RAM write must match the queue head.
    always @(negedge i_clock) begin
        if (i_reset) begin
            if (o_sample_valid != '0) begin
                chk("valid_onehot", 64'($countones(o_sample_valid)), 64'd1);
                if (exp_samples.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample actual=%0h required=none", o_sample_valid);
                end else begin
                    sample_t s;
                    s = exp_samples.pop_front();
                    chk("valid_voice", 64'(o_sample_valid), 64'(1 << s.voice));
                    chk("sample_data", 64'(o_sample[s.voice*DW +: DW]), 64'(s.data));
                end
            end
            if (o_ram_write_enable) begin
                if (exp_writes.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h required=none", o_ram_address);
                end else begin
                    write_t w;
                    w = exp_writes.pop_front();
                    chk("write_addr", 64'(o_ram_address), 64'(w.addr));
                    chk("write_data", 64'(o_ram_write_data), 64'(w.data));
                end
            end
        end
    end

    initial begin
        i_reset              = 1'b0;
        i_voice_address      = {13'h0040, 13'h0030, 13'h0020, 13'h0010};
        i_host_write_request = 1'b0;
        i_host_address       = '0;
        i_host_data          = '0;
        #12 check_outputs_zero("init");
        chk("init_ack", 64'(o_host_write_ack), 64'h0);

        // Round robin, frame period, first sample timing, mid-run reset.
        push_voices(12);
        release_rst();
        for (int k = 1; k <= 14; k++) begin
            @(posedge i_clock);
            @(negedge i_clock);
            chk("frame_start", 64'(o_frame_start), 64'(((k - 1) % 4) == 0));
            if (k == 2) chk("valid_cycle2", 64'(o_sample_valid), 64'h0);
            if (k == 3) chk("valid_cycle3", 64'(o_sample_valid), 64'h1);
        end
        chk("sample_all", 64'(o_sample), 64'h40302010);
        assert_rst();

        // Reset with voice 1 and voice 2 reads in flight: they must be dropped.
        push_voices(1);
        release_rst();
        repeat (3) begin
            @(posedge i_clock);
            @(negedge i_clock);
        end
        assert_rst();

        // Single host write while slot 2 is due.
        push_voices(9);
        push_write(13'h1ABC, 8'h5A);
        release_rst();
        repeat (2) @(posedge i_clock);
        #1;
        i_host_write_request = 1'b1;
        i_host_address       = 13'h1ABC;
        i_host_data          = 8'h5A;
        @(negedge i_clock);
        chk("single_ack", 64'(o_host_write_ack), 64'h1);
        @(posedge i_clock);
        #1 i_host_write_request = 1'b0;
        @(negedge i_clock);
        chk("single_ack_drop", 64'(o_host_write_ack), 64'h0);
        chk("single_we", 64'(o_ram_write_enable), 64'h1);
        @(posedge i_clock);
        @(negedge i_clock);
        chk("single_next_read", 64'(o_ram_address), 64'h30);
        chk("single_next_we", 64'(o_ram_write_enable), 64'h0);
        repeat (8) @(posedge i_clock);
        @(negedge i_clock);
        assert_rst();

        // Host requesting continuously for 8 cycles.
        push_voices(10);
        repeat (4) push_write(13'h0ABC, 8'hC3);
        release_rst();
        repeat (2) @(posedge i_clock);
        #1;
        i_host_write_request = 1'b1;
        i_host_address       = 13'h0ABC;
        i_host_data          = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clock);
            chk("burst_ack", 64'(o_host_write_ack), 64'((i % 2) == 0));
            @(posedge i_clock);
        end
        #1 i_host_write_request = 1'b0;
        repeat (6) @(posedge i_clock);
        @(negedge i_clock);
        assert_rst();

        // Host write at slot 3, then voice 3 and the wrap to voice 0.
        push_voices(7);
        push_write(13'h0777, 8'hA5);
        release_rst();
        repeat (3) @(posedge i_clock);
        #1;
        i_host_write_request = 1'b1;
        i_host_address       = 13'h0777;
        i_host_data          = 8'hA5;
        @(negedge i_clock);
        chk("wrap_ack", 64'(o_host_write_ack), 64'h1);
        @(posedge i_clock);
        #1 i_host_write_request = 1'b0;
        @(posedge i_clock);
        @(negedge i_clock);
        chk("wrap_voice3_addr", 64'(o_ram_address), 64'h40);
        chk("wrap_voice3_frame", 64'(o_frame_start), 64'h0);
        @(posedge i_clock);
        @(negedge i_clock);
        chk("wrap_voice0_addr", 64'(o_ram_address), 64'h10);
        chk("wrap_voice0_frame", 64'(o_frame_start), 64'h1);
        repeat (4) @(posedge i_clock);
        @(negedge i_clock);
        assert_rst();

        repeat (3) @(posedge i_clock);
        chk("samples_left", 64'(exp_samples.size()), 64'h0);
        chk("writes_left", 64'(exp_writes.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
